// File: rtl/regfile_port_master.sv
// Command-driven initiator for the register file write port and read port 1.
// Handles single WRITE/READ and whole-file FILL/DUMP, returning read data on a valid/ready stream.
module regfile_port_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              we3,
    output logic [ADDR_W-1:0] ra1,
    input  logic [DATA_W-1:0] rd1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_FILL,
        S_RD,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                dump_q, dump_d;
    logic [ADDR_W-1:0]   wa3_q, wa3_d;
    logic [DATA_W-1:0]   wd3_q, wd3_d;
    logic                we3_q, we3_d;
    logic [ADDR_W-1:0]   ra1_q, ra1_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                rsp_last_q, rsp_last_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dump_d      = dump_q;
        wa3_d       = wa3_q;
        wd3_d       = wd3_q;
        we3_d       = 1'b0;
        ra1_d       = ra1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_last_d  = rsp_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wa3_d  = cmd_addr;
                    wd3_d  = cmd_data;
                    ra1_d  = cmd_addr;
                    dump_d = 1'b0;
                    unique case (cmd_op)
                        OP_WRITE: begin
                            we3_d   = 1'b1;
                            state_d = S_WRITE;
                        end
                        OP_FILL: begin
                            we3_d   = 1'b1;
                            cnt_d   = '0;
                            wa3_d   = '0;
                            state_d = S_FILL;
                        end
                        OP_READ: begin
                            state_d = S_RD;
                        end
                        OP_DUMP: begin
                            dump_d  = 1'b1;
                            cnt_d   = '0;
                            ra1_d   = '0;
                            state_d = S_RD;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_WRITE: begin
                state_d = S_IDLE;
            end

            // Stop after the top address instead of letting the counter wrap to 0.
            S_FILL: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    we3_d = 1'b1;
                    cnt_d = cnt_q + ONE;
                    wa3_d = cnt_q + ONE;
                end
            end

            S_RD: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd1;
                rsp_addr_d  = ra1_q;
                rsp_last_d  = !dump_q || (ra1_q == LAST_ADDR);
                state_d     = S_RESP;
            end

            // Response and ra1 stay frozen until the consumer takes the beat.
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + ONE;
                        ra1_d   = ra1_q + ONE;
                        state_d = S_RD;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dump_q      <= 1'b0;
            wa3_q       <= '0;
            wd3_q       <= '0;
            we3_q       <= 1'b0;
            ra1_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dump_q      <= dump_d;
            wa3_q       <= wa3_d;
            wd3_q       <= wd3_d;
            we3_q       <= we3_d;
            ra1_q       <= ra1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign wa3       = wa3_q;
    assign wd3       = wd3_q;
    assign we3       = we3_q;
    assign ra1       = ra1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_regfile_port_master.sv
// Directed bench for regfile_port_master with a 16x8 register file attached to its ports.
module tb_regfile_port_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [3:0] wa3;
    logic [7:0] wd3;
    logic       we3;
    logic [3:0] ra1;
    logic [7:0] rd1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_addr;
    logic       rsp_last;
    logic       busy;

    logic [7:0] rf [16];
    logic       rf_clr;
    int         wr_cnt;
    logic [7:0] exp_rf [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_port_master #(.DATA_W(8), .ADDR_W(4), .NREGS(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .wa3(wa3), .wd3(wd3), .we3(we3), .ra1(ra1), .rd1(rd1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy)
    );

    // Register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'hF0 | 8'(i);
            wr_cnt <= 0;
        end else if (we3) begin
            rf[wa3] <= wd3;
            wr_cnt  <= wr_cnt + 1;
        end
    end
    assign rd1 = rf[ra1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge; the master is idle so it is taken at that edge.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 4'hE;
        cmd_data  = 8'hEE;
    endtask

    initial begin
        int w0;
        rst       = 1'b1;
        rf_clr    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 4'h0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        #1;
        chk("rst_we3", we3, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wa3", wa3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_ra1", ra1, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        tick();
        rst    = 1'b0;
        rf_clr = 1'b0;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);

        // WRITE 5 <- A7
        do_cmd(2'b00, 4'd5, 8'hA7);
        chk("wr_we3", we3, 1);
        chk("wr_wa3", wa3, 5);
        chk("wr_wd3", wd3, 8'hA7);
        chk("wr_busy", busy, 1);
        chk("wr_cmd_ready", cmd_ready, 0);
        tick();
        chk("wr_we3_drop", we3, 0);
        chk("wr_busy_drop", busy, 0);
        chk("wr_reg5", rf[5], 8'hA7);
        chk("wr_count", wr_cnt, 1);

        // READ 5 with rsp_ready held high
        rsp_ready = 1'b1;
        do_cmd(2'b01, 4'd5, 8'h00);
        chk("rd_valid_early", rsp_valid, 0);
        chk("rd_ra1", ra1, 5);
        tick();
        chk("rd_valid", rsp_valid, 1);
        chk("rd_data", rsp_data, 8'hA7);
        chk("rd_addr", rsp_addr, 5);
        chk("rd_last", rsp_last, 1);
        tick();
        chk("rd_valid_drop", rsp_valid, 0);
        chk("rd_idle", busy, 0);

        // FILL 3C: exactly 16 writes 0..15
        w0 = wr_cnt;
        do_cmd(2'b10, 4'd9, 8'h3C);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fill_we3_%0d", i), we3, 1);
            chk($sformatf("fill_wa3_%0d", i), wa3, i);
            chk($sformatf("fill_wd3_%0d", i), wd3, 8'h3C);
            tick();
        end
        chk("fill_we3_end", we3, 0);
        chk("fill_busy_end", busy, 0);
        tick();
        chk("fill_write_count", wr_cnt - w0, 16);
        for (int i = 0; i < 16; i++) exp_rf[i] = 8'h3C;
        for (int i = 0; i < 16; i++) chk($sformatf("fill_reg_%0d", i), rf[i], exp_rf[i]);

        // DUMP with rsp_ready always high
        do_cmd(2'b11, 4'd9, 8'h00);
        chk("dump_ra1_start", ra1, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("dump_valid_%0d", i), rsp_valid, 1);
            chk($sformatf("dump_data_%0d", i), rsp_data, 8'h3C);
            chk($sformatf("dump_addr_%0d", i), rsp_addr, i);
            chk($sformatf("dump_last_%0d", i), rsp_last, (i == 15) ? 1 : 0);
            tick();
            chk($sformatf("dump_gap_%0d", i), rsp_valid, 0);
        end
        chk("dump_done_busy", busy, 0);

        // Distinct data at 7 and 8, then DUMP with a 5-cycle stall at 7
        do_cmd(2'b00, 4'd7, 8'h77);
        tick();
        do_cmd(2'b00, 4'd8, 8'h88);
        tick();
        exp_rf[7] = 8'h77;
        exp_rf[8] = 8'h88;
        do_cmd(2'b11, 4'd3, 8'h00);
        for (int i = 0; i < 16; i++) begin
            if (i == 7) rsp_ready = 1'b0;
            tick();
            chk($sformatf("dump2_data_%0d", i), rsp_data, exp_rf[i]);
            chk($sformatf("dump2_addr_%0d", i), rsp_addr, i);
            if (i == 7) begin
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk($sformatf("stall_valid_%0d", k), rsp_valid, 1);
                    chk($sformatf("stall_data_%0d", k), rsp_data, 8'h77);
                    chk($sformatf("stall_addr_%0d", k), rsp_addr, 7);
                    chk($sformatf("stall_ra1_%0d", k), ra1, 7);
                end
                rsp_ready = 1'b1;
            end
            tick();
            chk($sformatf("dump2_gap_%0d", i), rsp_valid, 0);
            if (i < 15) chk($sformatf("dump2_ra1_%0d", i), ra1, i + 1);
        end
        chk("dump2_done_busy", busy, 0);

        // WRITE 2 held on cmd_valid throughout a FILL of 5A
        do_cmd(2'b10, 4'd0, 8'h5A);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_addr  = 4'd2;
        cmd_data  = 8'hE2;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("blk_cmd_ready_%0d", i), cmd_ready, 0);
            chk($sformatf("blk_wa3_%0d", i), wa3, i);
            chk($sformatf("blk_wd3_%0d", i), wd3, 8'h5A);
            tick();
        end
        chk("blk_cmd_ready_idle", cmd_ready, 1);
        chk("blk_reg2_fill", rf[2], 8'h5A);
        tick();
        cmd_valid = 1'b0;
        chk("blk_we3", we3, 1);
        chk("blk_wa3", wa3, 2);
        chk("blk_wd3", wd3, 8'hE2);
        tick();
        chk("blk_reg2_final", rf[2], 8'hE2);
        for (int i = 0; i < 16; i++) exp_rf[i] = 8'h5A;
        exp_rf[2] = 8'hE2;

        // Reset in the middle of a FILL of C3 while wa3 = 6
        do_cmd(2'b10, 4'd0, 8'hC3);
        repeat (6) tick();
        chk("mid_wa3", wa3, 6);
        chk("mid_we3", we3, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we3", we3, 0);
        chk("mid_rst_wa3", wa3, 0);
        chk("mid_rst_wd3", wd3, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) exp_rf[i] = 8'hC3;
        for (int i = 0; i < 16; i++) chk($sformatf("mid_reg_%0d", i), rf[i], exp_rf[i]);
        chk("mid_cmd_ready", cmd_ready, 1);

        // READ back through the master after the aborted fill
        do_cmd(2'b01, 4'd3, 8'h00);
        tick();
        chk("post_rd_valid", rsp_valid, 1);
        chk("post_rd_data", rsp_data, 8'hC3);
        chk("post_rd_addr", rsp_addr, 3);
        chk("post_rd_last", rsp_last, 1);
        tick();
        chk("post_rd_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_port_master.md
Name: regfile_port_master

Overview:
- Command-driven initiator for the 16x8 register file's write port (wa3/wd3/we3) and read port 1 (ra1/rd1).
- Accepts single-register write/read commands and whole-file fill/dump commands over a valid/ready command interface.
- Sequences the register-file port signals cycle by cycle and returns read data over a valid/ready response stream.
- Sits between the loader/debug logic and the register file, replacing direct pin-level driving of the write and read addresses.

Parameters:
DATA_W, 8, register data width (matches wd3/rd1)
ADDR_W, 4, register address width (matches wa3/ra1)
NREGS, 16, number of registers swept by fill/dump; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at rising edge
cmd_op  input  2  00 WRITE, 01 READ, 10 FILL, 11 DUMP
cmd_addr  input  ADDR_W  target register (WRITE/READ; ignored for FILL/DUMP)
cmd_data  input  DATA_W  write data (WRITE/FILL; ignored otherwise)
wa3  output  ADDR_W  register file write address
wd3  output  DATA_W  register file write data
we3  output  1  register file write enable
ra1  output  ADDR_W  register file read address
rd1  input  DATA_W  register file read data (combinational from ra1)
rsp_valid  output  1  response data valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  read data
rsp_addr  output  ADDR_W  address the data was read from
rsp_last  output  1  final response of a command (always 1 for READ, 1 only at addr NREGS-1 for DUMP)
busy  output  1  high in every state except IDLE

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high.
- Reset: state IDLE; we3, rsp_valid, rsp_last, busy = 0; wa3, wd3, ra1, rsp_data, rsp_addr = 0; internal counter = 0. cmd_ready = 1 immediately after reset deasserts.
- All outputs are registered, except cmd_ready = (state==IDLE) and busy = (state!=IDLE).
- FSM states: IDLE, WRITE, FILL, RD, RESP.
- IDLE: on cmd accept, latch cmd_addr/cmd_data into wa3/wd3 and ra1, then branch on cmd_op:
  - WRITE -> WRITE
  - FILL -> FILL, counter = 0, wa3 = 0
  - READ -> RD
  - DUMP -> RD, counter = 0, ra1 = 0
- WRITE: we3 = 1 for exactly this one cycle. Data lands in the register file at the rising edge ending the cycle. Next state IDLE. Accept-to-we3 latency is 1 cycle.
- FILL: we3 = 1 for NREGS consecutive cycles with wa3 = 0,1,...,NREGS-1 and wd3 constant. After the cycle with wa3 = NREGS-1, we3 = 0 and the FSM goes to IDLE.
  - The counter must not wrap to 0 and continue.
  - Total: 16 write cycles, busy for 16 cycles.
- RD: ra1 is stable. At the rising edge, capture rd1 -> rsp_data and ra1 -> rsp_addr, set rsp_valid = 1, set rsp_last = (READ) or (DUMP and ra1 == NREGS-1), then go to RESP. Accept-to-rsp_valid latency is 2 cycles.
- RESP: rsp_valid, rsp_data, rsp_addr and rsp_last are held stable until rsp_ready is sampled high. On handshake, rsp_valid = 0 and:
  - READ, or DUMP with rsp_last -> IDLE
  - otherwise DUMP: ra1 = ra1 + 1 -> RD
- DUMP throughput: 1 response per 2 cycles minimum.
- rsp_ready may be held high continuously. rsp_ready while rsp_valid = 0 has no effect.
- cmd_valid while busy is ignored (cmd_ready = 0). cmd_data/cmd_addr changes after accept have no effect.
- we3 is never asserted outside WRITE/FILL. ra1 is never changed while rsp_valid = 1.
- rst mid-operation: state, we3 and rsp_valid clear asynchronously. A partially completed FILL leaves the already-written registers as written. No response is emitted for an aborted READ/DUMP.

Test Plan:
- Reset, then WRITE addr=5 data=0xA7 -> we3=1 for exactly 1 cycle, wa3=5, wd3=0xA7, one cycle after accept; register 5 reads 0xA7; busy high 1 cycle.
- READ addr=5 with rsp_ready=1 -> rsp_valid rises 2 cycles after accept with rsp_data=0xA7, rsp_addr=5, rsp_last=1; back to IDLE the next cycle.
- FILL data=0x3C -> 16 consecutive we3 cycles, wa3 0..15, then we3=0; no 17th write at addr 0. DUMP then yields 16 responses of 0x3C, rsp_addr 0..15, rsp_last only on addr 15.
- DUMP with rsp_ready low for 5 cycles at addr 7 -> rsp_valid/rsp_data/rsp_addr held stable, ra1 stays 7; resumes at addr 8 after the handshake.
- cmd_valid held high with WRITE addr=2 during an in-progress FILL -> cmd_ready=0 and no write to reg 2 until FILL completes; command accepted in the first IDLE cycle.
- rst asserted mid-FILL at wa3=6 -> we3 drops asynchronously and outputs return to reset values; registers 0..5 hold the fill value, registers 6..15 are unchanged.
